store_axi_writer: RTL and testbench

- Write-side counterpart of the load-data extraction path in the multicycle-with-delay core.
- Takes a store request (address, register data, store size), shifts the data into the correct byte lanes and generates the write strobe.
- Issues one AXI4-Lite write (AW/W/B) to data memory, then returns a single completion pulse to the LSU control FSM.
- Sits between the EXU/LSU control and the data-side AXI arbiter.

---
 rtl/store_axi_writer_pkg.sv | 18 +
 rtl/store_lane_align.sv | 46 ++++
 rtl/store_axi_writer.sv | 144 ++++++++++++++
 tb/tb_store_axi_writer.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/store_axi_writer_pkg.sv
// Shared definitions for the store write path: store size encodings,
// AXI response codes and the writer FSM state type.
package store_axi_writer_pkg;

   localparam logic [1:0] OP_SB = 2'd0;
   localparam logic [1:0] OP_SH = 2'd1;
   localparam logic [1:0] OP_SW = 2'd2;

   localparam logic [1:0] RESP_OKAY = 2'b00;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SEND   = 2'd1,
      WAIT_B = 2'd2,
      FAULT  = 2'd3
   } state_t;

endpackage

// File: rtl/store_lane_align.sv
// Places LSB-justified store data into its byte lanes and builds the strobe;
// flags misaligned addresses and the reserved store op.
module store_lane_align
   import store_axi_writer_pkg::*;
(
   input  logic [1:0]  pos,
   input  logic [1:0]  op,
   input  logic [31:0] data,
   output logic [31:0] shifted,
   output logic [3:0]  strb,
   output logic        misalign,
   output logic        illegal
);

   // Rejected requests leave data and strobe at zero.
   always_comb begin
      shifted  = '0;
      strb     = '0;
      misalign = 1'b0;
      illegal  = 1'b0;
      case (op)
         OP_SB: begin
            strb    = 4'b0001 << pos;
            shifted = {24'b0, data[7:0]} << {pos, 3'b000};
         end
         OP_SH: begin
            if (pos == 2'd3) begin
               misalign = 1'b1;
            end else begin
               strb    = 4'b0011 << pos;
               shifted = {16'b0, data[15:0]} << {pos, 3'b000};
            end
         end
         OP_SW: begin
            if (pos != 2'd0) begin
               misalign = 1'b1;
            end else begin
               strb    = 4'hF;
               shifted = data;
            end
         end
         default: illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/store_axi_writer.sv
// Store request to single AXI4-Lite write: lane alignment at accept, then
// independent AW/W handshakes, B response, and a one-cycle done/err pulse.
module store_axi_writer
   import store_axi_writer_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   input  logic [1:0]        req_writeop,
   output logic              awvalid,
   input  logic              awready,
   output logic [ADDR_W-1:0] awaddr,
   output logic              wvalid,
   input  logic              wready,
   output logic [DATA_W-1:0] wdata,
   output logic [3:0]        wstrb,
   input  logic              bvalid,
   output logic              bready,
   input  logic [1:0]        bresp,
   output logic              done,
   output logic              err
);

   state_t            state, state_nxt;
   logic              aw_done, aw_done_nxt;
   logic              w_done, w_done_nxt;
   logic              awvalid_nxt, wvalid_nxt, bready_nxt;
   logic              done_nxt, err_nxt;
   logic [ADDR_W-1:0] awaddr_nxt;
   logic [DATA_W-1:0] wdata_nxt;
   logic [3:0]        wstrb_nxt;

   logic [31:0]       align_data;
   logic [3:0]        align_strb;
   logic              align_misalign, align_illegal;

   store_lane_align u_align (
      .pos      (req_addr[1:0]),
      .op       (req_writeop),
      .data     (req_wdata),
      .shifted  (align_data),
      .strb     (align_strb),
      .misalign (align_misalign),
      .illegal  (align_illegal)
   );

   assign req_ready = (state == IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         aw_done <= 1'b0;
         w_done  <= 1'b0;
         awvalid <= 1'b0;
         wvalid  <= 1'b0;
         bready  <= 1'b0;
         done    <= 1'b0;
         err     <= 1'b0;
         awaddr  <= '0;
         wdata   <= '0;
         wstrb   <= '0;
      end else begin
         state   <= state_nxt;
         aw_done <= aw_done_nxt;
         w_done  <= w_done_nxt;
         awvalid <= awvalid_nxt;
         wvalid  <= wvalid_nxt;
         bready  <= bready_nxt;
         done    <= done_nxt;
         err     <= err_nxt;
         awaddr  <= awaddr_nxt;
         wdata   <= wdata_nxt;
         wstrb   <= wstrb_nxt;
      end
   end

   // Rejected requests raise done/err on entry to FAULT so the pulse
   // lands one cycle after accept; bready is only raised once both
   // AW and W have completed, so an early B is never taken.
   always_comb begin
      state_nxt   = state;
      aw_done_nxt = aw_done;
      w_done_nxt  = w_done;
      awvalid_nxt = awvalid;
      wvalid_nxt  = wvalid;
      bready_nxt  = bready;
      done_nxt    = 1'b0;
      err_nxt     = 1'b0;
      awaddr_nxt  = awaddr;
      wdata_nxt   = wdata;
      wstrb_nxt   = wstrb;
      case (state)
         IDLE: begin
            if (req_valid) begin
               if (align_misalign || align_illegal) begin
                  state_nxt = FAULT;
                  done_nxt  = 1'b1;
                  err_nxt   = 1'b1;
               end else begin
                  awaddr_nxt  = req_addr;
                  wdata_nxt   = align_data;
                  wstrb_nxt   = align_strb;
                  awvalid_nxt = 1'b1;
                  wvalid_nxt  = 1'b1;
                  aw_done_nxt = 1'b0;
                  w_done_nxt  = 1'b0;
                  state_nxt   = SEND;
               end
            end
         end
         SEND: begin
            if (awvalid && awready) begin
               awvalid_nxt = 1'b0;
               aw_done_nxt = 1'b1;
            end
            if (wvalid && wready) begin
               wvalid_nxt = 1'b0;
               w_done_nxt = 1'b1;
            end
            if (aw_done_nxt && w_done_nxt) begin
               bready_nxt = 1'b1;
               state_nxt  = WAIT_B;
            end
         end
         WAIT_B: begin
            if (bvalid) begin
               bready_nxt = 1'b0;
               done_nxt   = 1'b1;
               err_nxt    = (bresp != RESP_OKAY);
               state_nxt  = IDLE;
            end
         end
         FAULT: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_store_axi_writer.sv
// Self-checking bench for store_axi_writer: directed store requests against a
// simple AXI slave, with a byte-count based model of lanes, strobes and errors.
module tb_store_axi_writer;

   logic        clk;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [1:0]  req_writeop;
   logic        awvalid, awready;
   logic [31:0] awaddr;
   logic        wvalid, wready;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        bvalid, bready;
   logic [1:0]  bresp;
   logic        done, err;

   typedef struct {
      logic        legal;
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  strb;
      logic        exp_err;
   } exp_t;

   exp_t        cur;
   int          checks = 0;
   int          errors = 0;
   int          aw_count, w_count, b_count;
   int          w_stall_left = 0;
   bit          cfg_early_b = 0;
   bit          cfg_b_hold = 0;
   logic [1:0]  cfg_resp = 2'b00;
   logic [31:0] last_awaddr, last_wdata;
   logic [3:0]  last_wstrb;
   logic        seen_err;

   store_axi_writer #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_addr    (req_addr),
      .req_wdata   (req_wdata),
      .req_writeop (req_writeop),
      .awvalid     (awvalid),
      .awready     (awready),
      .awaddr      (awaddr),
      .wvalid      (wvalid),
      .wready      (wready),
      .wdata       (wdata),
      .wstrb       (wstrb),
      .bvalid      (bvalid),
      .bready      (bready),
      .bresp       (bresp),
      .done        (done),
      .err         (err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: actual=0x%08h expected=0x%08h", name, actual, expected);
      end
   endtask

   // A store covers 'bytes' consecutive lanes starting at pos and must fit in the word.
   function automatic void modelStore(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] op,
                                      output logic legal, output logic [31:0] wd, output logic [3:0] st);
      int         pos;
      int         bytes;
      logic [63:0] mask;
      pos   = int'(addr[1:0]);
      bytes = (op == 2'd0) ? 1 : (op == 2'd1) ? 2 : 4;
      legal = (op != 2'd3) && (pos + bytes <= 4);
      mask  = (64'd1 << (8 * bytes)) - 64'd1;
      wd    = legal ? 32'((64'(data) & mask) << (8 * pos)) : 32'd0;
      st    = legal ? 4'(((1 << bytes) - 1) << pos) : 4'd0;
   endfunction

   // Simple slave: AW always ready, W ready after an optional stall, B follows bready.
   initial begin
      awready = 1'b0;
      wready  = 1'b0;
      bvalid  = 1'b0;
      bresp   = 2'b00;
      forever begin
         @(posedge clk);
         #1;
         awready = 1'b1;
         if (wvalid && w_stall_left > 0) begin
            wready = 1'b0;
            w_stall_left--;
         end else begin
            wready = 1'b1;
         end
         bvalid = !cfg_b_hold && (bready || cfg_early_b);
         bresp  = cfg_resp;
      end
   end

   // Per-cycle comparison of the bus outputs against the current expectation.
   initial begin
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (awvalid) checkOutput("awaddr", awaddr, cur.addr);
            if (wvalid) begin
               checkOutput("wdata", wdata, cur.data);
               checkOutput("wstrb", 32'(wstrb), 32'(cur.strb));
            end
            if (awvalid || wvalid) checkOutput("bready_in_send", 32'(bready), 32'd0);
            if (!cur.legal) checkOutput("no_bus_on_fault", 32'(awvalid | wvalid), 32'd0);
            if (awvalid && awready) begin
               aw_count++;
               last_awaddr = awaddr;
            end
            if (wvalid && wready) begin
               w_count++;
               last_wdata = wdata;
               last_wstrb = wstrb;
            end
            if (bvalid && bready) b_count++;
            if (done) checkOutput("done_err", 32'(err), 32'(cur.exp_err));
         end
      end
   end

   task automatic applyStimulus(input string name, input logic [31:0] addr, input logic [31:0] data,
                                input logic [1:0] op, input logic [1:0] resp, input int wstall,
                                input bit early, input int exp_lat);
      int lat;
      int exp_hs;
      @(negedge clk);
      checkOutput({name, "_req_ready"}, 32'(req_ready), 32'd1);
      modelStore(addr, data, op, cur.legal, cur.data, cur.strb);
      cur.addr    = addr;
      cur.exp_err = !cur.legal || (resp != 2'b00);
      cfg_resp     = resp;
      cfg_early_b  = early;
      w_stall_left = wstall;
      aw_count = 0;
      w_count  = 0;
      b_count  = 0;
      req_valid   = 1'b1;
      req_addr    = addr;
      req_wdata   = data;
      req_writeop = op;
      @(negedge clk);
      req_valid = 1'b0;
      lat = 0;
      for (int k = 1; k <= 40; k++) begin
         if (done) begin
            lat = k;
            seen_err = err;
            break;
         end
         @(negedge clk);
      end
      if (lat == 0) begin
         checkOutput({name, "_done_timeout"}, 32'd0, 32'd1);
      end else begin
         exp_hs = cur.legal ? 1 : 0;
         checkOutput({name, "_latency"}, 32'(lat), 32'(exp_lat));
         checkOutput({name, "_aw_count"}, 32'(aw_count), 32'(exp_hs));
         checkOutput({name, "_w_count"}, 32'(w_count), 32'(exp_hs));
         checkOutput({name, "_b_count"}, 32'(b_count), 32'(exp_hs));
         @(negedge clk);
         checkOutput({name, "_done_one_cycle"}, 32'(done), 32'd0);
      end
   endtask

   task automatic resetInWaitB();
      bit reached;
      @(negedge clk);
      modelStore(32'h80000010, 32'h01020304, 2'd2, cur.legal, cur.data, cur.strb);
      cur.addr    = 32'h80000010;
      cur.exp_err = 1'b0;
      cfg_resp     = 2'b00;
      cfg_early_b  = 1'b0;
      cfg_b_hold   = 1'b1;
      w_stall_left = 0;
      req_valid   = 1'b1;
      req_addr    = 32'h80000010;
      req_wdata   = 32'h01020304;
      req_writeop = 2'd2;
      @(negedge clk);
      req_valid = 1'b0;
      reached = 1'b0;
      for (int k = 0; k < 10; k++) begin
         if (bready) begin
            reached = 1'b1;
            break;
         end
         @(negedge clk);
      end
      checkOutput("rst_reached_wait_b", 32'(reached), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("rst_async_ctrl", 32'({awvalid, wvalid, bready, done, err}), 32'd0);
      checkOutput("rst_async_awaddr", awaddr, 32'd0);
      checkOutput("rst_async_wdata", wdata, 32'd0);
      checkOutput("rst_async_wstrb", 32'(wstrb), 32'd0);
      checkOutput("rst_async_ready", 32'(req_ready), 32'd1);
      cfg_b_hold = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         checkOutput("rst_no_done", 32'(done), 32'd0);
      end
   endtask

   initial begin
      rst_n       = 1'b0;
      req_valid   = 1'b0;
      req_addr    = '0;
      req_wdata   = '0;
      req_writeop = '0;
      cur.legal   = 1'b1;
      cur.addr    = '0;
      cur.data    = '0;
      cur.strb    = '0;
      cur.exp_err = 1'b0;
      #12;
      checkOutput("reset_ctrl", 32'({awvalid, wvalid, bready, done, err}), 32'd0);
      checkOutput("reset_awaddr", awaddr, 32'd0);
      checkOutput("reset_wdata", wdata, 32'd0);
      checkOutput("reset_wstrb", 32'(wstrb), 32'd0);
      checkOutput("reset_ready", 32'(req_ready), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;

      applyStimulus("sb_pos3", 32'h80000003, 32'h123456AB, 2'd0, 2'b00, 0, 1'b0, 3);
      checkOutput("sb_pos3_awaddr_lit", last_awaddr, 32'h80000003);
      checkOutput("sb_pos3_wdata_lit", last_wdata, 32'hAB000000);
      checkOutput("sb_pos3_wstrb_lit", 32'(last_wstrb), 32'h8);
      checkOutput("sb_pos3_err_lit", 32'(seen_err), 32'd0);

      applyStimulus("sh_pos1", 32'h80000101, 32'hFFFFBEEF, 2'd1, 2'b00, 0, 1'b0, 3);
      checkOutput("sh_pos1_wdata_lit", last_wdata, 32'h00BEEF00);
      checkOutput("sh_pos1_wstrb_lit", 32'(last_wstrb), 32'h6);

      applyStimulus("sh_pos3", 32'h80000103, 32'hFFFFBEEF, 2'd1, 2'b00, 0, 1'b0, 1);
      checkOutput("sh_pos3_err_lit", 32'(seen_err), 32'd1);

      applyStimulus("sh_pos2", 32'h80000002, 32'h0000A5C3, 2'd1, 2'b00, 0, 1'b0, 3);
      checkOutput("sh_pos2_wdata_lit", last_wdata, 32'hA5C30000);
      checkOutput("sh_pos2_wstrb_lit", 32'(last_wstrb), 32'hC);

      applyStimulus("sw_wstall", 32'h80000200, 32'hDEADBEEF, 2'd2, 2'b00, 3, 1'b0, 6);
      checkOutput("sw_wstall_wdata_lit", last_wdata, 32'hDEADBEEF);
      checkOutput("sw_wstall_wstrb_lit", 32'(last_wstrb), 32'hF);

      applyStimulus("sw_slverr", 32'h80000204, 32'hCAFEF00D, 2'd2, 2'b10, 2, 1'b1, 5);
      checkOutput("sw_slverr_err_lit", 32'(seen_err), 32'd1);

      applyStimulus("op_reserved", 32'h80000300, 32'h11111111, 2'd3, 2'b00, 0, 1'b0, 1);
      checkOutput("op_reserved_err_lit", 32'(seen_err), 32'd1);

      applyStimulus("sw_pos2", 32'h80000302, 32'h22222222, 2'd2, 2'b00, 0, 1'b0, 1);
      checkOutput("sw_pos2_err_lit", 32'(seen_err), 32'd1);

      resetInWaitB();

      applyStimulus("sb_after_rst", 32'h80000001, 32'hFFFFFF77, 2'd0, 2'b00, 0, 1'b0, 3);
      checkOutput("sb_after_rst_wdata_lit", last_wdata, 32'h00007700);
      checkOutput("sb_after_rst_wstrb_lit", 32'(last_wstrb), 32'h2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
